// File: rtl/frame_buffer_arbiter_if.sv
// Bundles the video scan, drawing-client and single-port RAM signals of the
// frame buffer arbiter; slave is the arbiter side, master the surrounding system.
interface frame_buffer_arbiter_if;
  logic        pixelEn;
  logic [8:0]  row;
  logic [9:0]  column;
  logic        displayActive;
  logic        pixel;
  logic        wrReq;
  logic [14:0] wrAddr;
  logic [15:0] wrData;
  logic        wrAck;
  logic [14:0] memAddr;
  logic        memWe;
  logic [15:0] memWdata;
  logic [15:0] memRdata;

  modport slave (
    input  pixelEn, row, column, displayActive, wrReq, wrAddr, wrData, memRdata,
    output pixel, wrAck, memAddr, memWe, memWdata
  );

  modport master (
    output pixelEn, row, column, displayActive, wrReq, wrAddr, wrData, memRdata,
    input  pixel, wrAck, memAddr, memWe, memWdata
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port RAM between the VGA scan-out prefetch and a drawing
// client; display reads always win, writes fill the remaining cycles.
module frame_buffer_arbiter #(
  parameter int WORDS_PER_LINE = 40,
  parameter int ACTIVE_ROWS    = 480
) (
  input logic clk,
  input logic rst,
  frame_buffer_arbiter_if.slave bus
);

  localparam logic [9:0] LAST_RD_COL = 10'((WORDS_PER_LINE - 2) * 16 + 1);
  localparam logic [8:0] LAST_ROW    = 9'(ACTIVE_ROWS - 1);
  localparam logic [9:0] WRAP_COL    = 10'd784;

  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        wr_ack;
  logic        pixel;
  logic [15:0] cur_word;
  logic [15:0] next_word;
  logic        rd_d1;
  logic        rd_d2;

  logic        wrap_read;
  logic        word_read;
  logic        rd_now;
  logic        wr_now;
  logic [8:0]  next_row;
  logic [14:0] rd_addr;

  function automatic logic [14:0] row_base(input logic [8:0] r);
    logic [14:0] rx;
    rx = {6'd0, r};
    return (rx << 5) + (rx << 3);
  endfunction

  always_comb begin
    wrap_read = 1'b0;
    word_read = 1'b0;
    next_row  = 9'd0;
    rd_addr   = 15'd0;
    wrap_read = bus.pixelEn && (bus.column == WRAP_COL);
    word_read = bus.pixelEn && (bus.column[3:0] == 4'd1) && (bus.column <= LAST_RD_COL);
    rd_now    = wrap_read || word_read;
    next_row  = (bus.row < LAST_ROW) ? bus.row + 9'd1 : 9'd0;
    // Word reads fetch one word ahead of the word currently being shifted out.
    if (wrap_read)
      rd_addr = row_base(next_row);
    else
      rd_addr = row_base(bus.row) + {9'd0, bus.column[9:4]} + 15'd1;
    wr_now = !rd_now && bus.wrReq && !wr_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= 15'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 16'd0;
      wr_ack    <= 1'b0;
      pixel     <= 1'b0;
      cur_word  <= 16'd0;
      next_word <= 16'd0;
      rd_d1     <= 1'b0;
      rd_d2     <= 1'b0;
    end else begin
      rd_d1  <= rd_now;
      rd_d2  <= rd_d1;
      wr_ack <= wr_now;
      mem_we <= wr_now;
      if (rd_now) begin
        mem_addr <= rd_addr;
      end else if (wr_now) begin
        mem_addr  <= bus.wrAddr;
        mem_wdata <= bus.wrData;
      end
      // RAM returns data one cycle after the address register updates.
      if (rd_d2)
        next_word <= bus.memRdata;
      if (bus.pixelEn) begin
        pixel <= bus.displayActive & cur_word[~bus.column[3:0]];
        if (bus.column[3:0] == 4'd15)
          cur_word <= next_word;
      end
    end
  end

  assign bus.memAddr  = mem_addr;
  assign bus.memWe    = mem_we;
  assign bus.memWdata = mem_wdata;
  assign bus.wrAck    = wr_ack;
  assign bus.pixel    = pixel;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: a RAM model plus a shadow of everything the
// client wrote; arbitration and scan-out are predicted from the addressing rules.
module tb_frame_buffer_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_arbiter_if bus();

  frame_buffer_arbiter #(.WORDS_PER_LINE(40), .ACTIVE_ROWS(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] ram    [0:32767];
  logic [15:0] shadow [0:32767];
  logic [15:0] ram_q;

  always @(posedge clk) begin
    if (bus.memWe) ram[bus.memAddr] <= bus.memWdata;
    ram_q <= ram[bus.memAddr];
  end
  assign bus.memRdata = ram_q;

  int n_assert = 0;
  int n_fail   = 0;

  logic        exp_ack;
  logic [14:0] exp_addr;
  logic [15:0] exp_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req();
    bus.wrReq  = 1'b1;
    bus.wrAddr = 15'($urandom_range(0, 32767));
    bus.wrData = 16'($urandom);
  endtask

  // One clock of arbitration, predicted from the current inputs.
  task automatic cycle_check(input string tag);
    bit rd, iss;
    int r, c;
    logic [14:0] wa;
    logic [15:0] wd;
    r   = int'(bus.row);
    c   = int'(bus.column);
    rd  = bus.pixelEn && (((c % 16) == 1 && c <= 609) || c == 784);
    iss = !rd && bus.wrReq && !exp_ack;
    wa  = bus.wrAddr;
    wd  = bus.wrData;
    if (rd) begin
      if (c == 784) exp_addr = 15'(((r < 479) ? r + 1 : 0) * 40);
      else          exp_addr = 15'(r * 40 + c / 16 + 1);
    end else if (iss) begin
      exp_addr  = wa;
      exp_wdata = wd;
    end
    tick();
    chk({tag, "_ack"},   32'(bus.wrAck),    32'(iss));
    chk({tag, "_we"},    32'(bus.memWe),    32'(iss));
    chk({tag, "_addr"},  32'(bus.memAddr),  32'(exp_addr));
    chk({tag, "_wdata"}, 32'(bus.memWdata), 32'(exp_wdata));
    if (iss) shadow[wa] = wd;
    exp_ack = iss;
  endtask

  task automatic pixel_step(input int r, input int c, input bit da, output logic px);
    bus.pixelEn       = 1'b1;
    bus.row           = 9'(r);
    bus.column        = 10'(c);
    bus.displayActive = da;
    tick();
    px = bus.pixel;
    bus.pixelEn = 1'b0;
    tick();
  endtask

  // Prefetch from the tail of the previous row, then scan the whole row.
  task automatic scan_line(input int r, input bit active, output logic [15:0] first_word_px);
    logic px;
    logic [15:0] w;
    bit exp;
    int prev;
    prev = (r == 0) ? 479 : r - 1;
    first_word_px = 16'd0;
    for (int c = 784; c < 800; c++) begin
      pixel_step(prev, c, 1'b0, px);
      chk("pre_px", 32'(px), 32'd0);
    end
    for (int c = 0; c < 800; c++) begin
      pixel_step(r, c, active && (c < 640), px);
      w   = shadow[r * 40 + (c < 640 ? c / 16 : 0)];
      exp = active && (c < 640) && w[15 - (c % 16)];
      chk($sformatf("px_r%0d_c%0d", r, c), 32'(px), 32'(exp));
      if (c < 16) first_word_px[15 - c] = px;
    end
  endtask

  initial begin
    int n_ack;
    int sel;
    logic [15:0] fw;
    logic [15:0] v;

    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      ram[i]    = v;
      shadow[i] = v;
    end
    bus.pixelEn = 1'b0; bus.row = 9'd0; bus.column = 10'd0; bus.displayActive = 1'b0;
    bus.wrReq = 1'b0; bus.wrAddr = 15'd0; bus.wrData = 16'd0;
    exp_ack = 1'b0; exp_addr = 15'd0; exp_wdata = 16'd0;

    tick(); tick();
    chk("rst_addr",  32'(bus.memAddr),  32'd0);
    chk("rst_we",    32'(bus.memWe),    32'd0);
    chk("rst_wdata", 32'(bus.memWdata), 32'd0);
    chk("rst_ack",   32'(bus.wrAck),    32'd0);
    chk("rst_pixel", 32'(bus.pixel),    32'd0);
    #2 rst = 1'b1;

    // Continuous write stream, no display traffic.
    new_req();
    n_ack = 0;
    for (int i = 0; i < 40; i++) begin
      cycle_check("w_stream");
      n_ack += int'(bus.wrAck);
      if (exp_ack) new_req();
    end
    chk("w_stream_acks", 32'(n_ack), 32'd20);

    // Random mix of display reads and client writes.
    bus.wrReq = 1'b0;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 3));
      bus.pixelEn = 1'($urandom);
      bus.row     = 9'($urandom_range(0, 479));
      case (sel)
        0: bus.column = 10'($urandom_range(0, 799));
        1: bus.column = 10'(16 * $urandom_range(0, 49) + 1);
        2: bus.column = 10'd784;
        default: bus.column = ($urandom_range(0, 1) == 0) ? 10'd609 : 10'd625;
      endcase
      if (exp_ack) begin
        if ($urandom_range(0, 1) == 0) new_req(); else bus.wrReq = 1'b0;
      end else if (!bus.wrReq && $urandom_range(0, 2) == 0) begin
        new_req();
      end
      cycle_check("mix");
    end
    bus.pixelEn = 1'b0;
    bus.wrReq   = 1'b0;
    cycle_check("idle");
    cycle_check("idle");

    // Known pattern at the start of row 1.
    bus.wrReq = 1'b1; bus.wrAddr = 15'd40; bus.wrData = 16'h8001;
    cycle_check("w40");
    bus.wrReq = 1'b0;
    cycle_check("w40_idle");

    // Write arriving together with a display read.
    bus.wrReq = 1'b1; bus.wrAddr = 15'd20000; bus.wrData = 16'h1234;
    bus.pixelEn = 1'b1; bus.row = 9'd5; bus.column = 10'd17;
    cycle_check("col17");
    chk("col17_rdaddr", 32'(bus.memAddr), 32'd202);
    bus.pixelEn = 1'b0;
    cycle_check("col17_wr");
    chk("col17_wraddr", 32'(bus.memAddr), 32'd20000);
    bus.wrReq = 1'b0;
    cycle_check("col17_idle");

    // Row wrap and last-word boundaries.
    bus.pixelEn = 1'b1; bus.row = 9'd479; bus.column = 10'd784;
    cycle_check("wrap479");
    chk("wrap479_addr", 32'(bus.memAddr), 32'd0);
    bus.row = 9'd10;
    cycle_check("wrap10");
    chk("wrap10_addr", 32'(bus.memAddr), 32'd440);
    bus.row = 9'd2; bus.column = 10'd609;
    cycle_check("col609");
    chk("col609_addr", 32'(bus.memAddr), 32'd119);
    bus.column = 10'd625;
    cycle_check("col625");
    chk("col625_addr", 32'(bus.memAddr), 32'd119);
    bus.pixelEn = 1'b0;
    cycle_check("bnd_idle");

    // Scan-out.
    scan_line(1, 1'b1, fw);
    chk("row1_px0",  32'(fw[15]),   32'd1);
    chk("row1_px15", 32'(fw[0]),    32'd1);
    chk("row1_mid",  32'(fw[14:1]), 32'd0);
    scan_line(0, 1'b1, fw);
    scan_line(479, 1'b1, fw);
    for (int i = 280; i < 320; i++) begin
      ram[i]    = 16'hFFFF;
      shadow[i] = 16'hFFFF;
    end
    scan_line(7, 1'b0, fw);
    chk("blank_word0", 32'(fw), 32'd0);

    // Reset mid-line with a write waiting behind a display read.
    bus.wrReq = 1'b1; bus.wrAddr = 15'd123; bus.wrData = 16'hBEEF;
    bus.pixelEn = 1'b1; bus.row = 9'd3; bus.column = 10'd1;
    tick();
    chk("prerst_addr", 32'(bus.memAddr), 32'd121);
    chk("prerst_ack",  32'(bus.wrAck),   32'd0);
    bus.pixelEn = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_addr",  32'(bus.memAddr),  32'd0);
    chk("arst_we",    32'(bus.memWe),    32'd0);
    chk("arst_wdata", 32'(bus.memWdata), 32'd0);
    chk("arst_ack",   32'(bus.wrAck),    32'd0);
    chk("arst_pixel", 32'(bus.pixel),    32'd0);
    tick(); tick();
    chk("inrst_ack", 32'(bus.wrAck), 32'd0);
    chk("inrst_we",  32'(bus.memWe), 32'd0);
    #2 rst = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.wrAck) begin
        n_ack++;
        chk("reissue_addr",  32'(bus.memAddr),  32'd123);
        chk("reissue_wdata", 32'(bus.memWdata), 32'hBEEF);
        shadow[123] = 16'hBEEF;
        bus.wrReq = 1'b0;
      end
      if (i == 0) chk("reissue_first", 32'(bus.wrAck), 32'd1);
    end
    chk("reissue_acks", 32'(n_ack), 32'd1);

    scan_line(7, 1'b1, fw);
    chk("postrst_word0", 32'(fw), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
